sync_fwft_fifo_36x512: RTL and testbench

- Single-clock, first-word-fall-through FIFO: 36-bit data, 512 words deep.
- Used as the read-burst buffer between the memory read path and a downstream consumer.
- The head word is always presented on Q while Empty is low; RdEn acknowledges (pops) it.
- Almost_Full lets the upstream stop issuing bursts before overflow.

---
 rtl/sync_fwft_fifo_36x512_pkg.sv | 20 ++
 rtl/sync_fwft_fifo_36x512_if.sv | 34 +++
 rtl/sdp_ram_36x512.sv | 29 ++
 rtl/sync_fwft_fifo_36x512.sv | 85 ++++++++
 tb/tb_sync_fwft_fifo_36x512.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/sync_fwft_fifo_36x512_pkg.sv
// Shared constants and types for the 36x512 first-word-fall-through FIFO.
package fifo_pkg;

  localparam int DSIZE        = 36;
  localparam int DEPTH        = 512;
  localparam int AW           = 9;
  localparam int AFULL_THRESH = 496;

  typedef logic [DSIZE-1:0] data_t;
  typedef logic [AW-1:0]    ptr_t;
  typedef logic [AW:0]      cnt_t;

  localparam cnt_t CNT_FULL  = cnt_t'(DEPTH);
  localparam cnt_t CNT_AFULL = cnt_t'(AFULL_THRESH);

  function automatic ptr_t ptr_inc(input ptr_t p);
    return p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/sync_fwft_fifo_36x512_if.sv
// Write/read handshake bundle of the FWFT FIFO.
// Wnum/Almost_Empty exist only when FIFO_STATUS_EN is defined.
interface sync_fwft_fifo_36x512_if;
  import fifo_pkg::*;

  logic  WrEn;
  data_t Data;
  logic  Almost_Full;
  logic  Full;
  logic  RdEn;
  data_t Q;
  logic  Empty;
`ifdef FIFO_STATUS_EN
  cnt_t  Wnum;
  logic  Almost_Empty;
`endif

  modport master (
    output WrEn, Data, RdEn,
    input  Almost_Full, Full, Q, Empty
`ifdef FIFO_STATUS_EN
    , input Wnum, Almost_Empty
`endif
  );

  modport slave (
    input  WrEn, Data, RdEn,
    output Almost_Full, Full, Q, Empty
`ifdef FIFO_STATUS_EN
    , output Wnum, Almost_Empty
`endif
  );

endinterface

// File: rtl/sdp_ram_36x512.sv
// Simple dual-port RAM, synchronous read; only the read register resets.
module sdp_ram_36x512
  import fifo_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  we_i,
  input  ptr_t  waddr_i,
  input  data_t wdata_i,
  input  logic  re_i,
  input  ptr_t  raddr_i,
  output data_t rdata_o
);

  data_t mem [DEPTH];
  data_t rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fwft_fifo_36x512.sv
// Single-clock FWFT FIFO, 36 bits x 512; RAM read register is the head stage.
// Optional status outputs (Wnum, Almost_Empty) under FIFO_STATUS_EN.
module sync_fwft_fifo_36x512
  import fifo_pkg::*;
(
  input logic                    Clk,
  input logic                    Reset,
  sync_fwft_fifo_36x512_if.slave bus
);

  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  rd_ptr_q, rd_ptr_d;
  cnt_t  cnt_q, cnt_d;
  logic  full_q, full_d;
  logic  afull_q, afull_d;
  logic  oval_q, oval_d;
  logic  wr_acc, rd_acc;
  logic  ram_avail, load;
  data_t q;

  // cnt_q includes the head word; RAM holds cnt_q - oval_q unread words
  always_comb begin
    wr_acc    = bus.WrEn && !full_q;
    rd_acc    = bus.RdEn && oval_q;
    ram_avail = cnt_q != cnt_t'(oval_q);
    load      = ram_avail && (!oval_q || rd_acc);
    wr_ptr_d  = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = load ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    oval_d    = load || (oval_q && !rd_acc);
    cnt_d     = cnt_q;
    if (wr_acc && !rd_acc)      cnt_d = cnt_q + cnt_t'(1);
    else if (!wr_acc && rd_acc) cnt_d = cnt_q - cnt_t'(1);
    full_d    = cnt_d == CNT_FULL;
    afull_d   = cnt_d >= CNT_AFULL;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      oval_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      oval_q   <= oval_d;
    end
  end

  sdp_ram_36x512 u_ram (
    .clk_i   (Clk),
    .rst_ni  (Reset),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.Data),
    .re_i    (load),
    .raddr_i (rd_ptr_q),
    .rdata_o (q)
  );

  assign bus.Q           = q;
  assign bus.Empty       = !oval_q;
  assign bus.Full        = full_q;
  assign bus.Almost_Full = afull_q;

`ifdef FIFO_STATUS_EN
  logic aempty_q, aempty_d;

  always_comb aempty_d = cnt_d <= cnt_t'(1);

  always_ff @(posedge Clk) begin
    if (!Reset) aempty_q <= 1'b1;
    else        aempty_q <= aempty_d;
  end

  assign bus.Wnum         = cnt_q;
  assign bus.Almost_Empty = aempty_q;
`endif

endmodule

// File: tb/tb_sync_fwft_fifo_36x512.sv
// Scoreboard bench for sync_fwft_fifo_36x512 with a queue reference model.
module tb_sync_fwft_fifo_36x512;

  typedef struct {
    logic [35:0] d;
    int          e;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic chk_en = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   edge_cnt = 0;

  ent_t        mq[$];
  logic [35:0] sb[$];

  sync_fwft_fifo_36x512_if bus();

  sync_fwft_fifo_36x512 dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic head_vis();
    return mq.size() > 0 && mq[0].e + 1 < edge_cnt;
  endfunction

  task automatic chk(input string nm,
                     input logic [35:0] act,
                     input logic [35:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: contents in order, each tagged with its accept edge
  always @(posedge clk) begin
    logic vis, wr, rd;
    vis = head_vis();
    if (!rst) begin
      mq.delete();
      sb.delete();
    end else begin
      wr = bus.WrEn && mq.size() < 512;
      rd = bus.RdEn && vis;
      if (rd) void'(mq.pop_front());
      if (wr) begin
        mq.push_back('{bus.Data, edge_cnt});
        sb.push_back(bus.Data);
      end
    end
    edge_cnt++;
  end

  // Monitor: flags every cycle, data on each pop the DUT presents
  always @(negedge clk) begin
    if (chk_en) begin
      chk("empty", 36'(bus.Empty), 36'(!head_vis()));
      chk("full", 36'(bus.Full), 36'(mq.size() == 512));
      chk("afull", 36'(bus.Almost_Full), 36'(mq.size() >= 496));
`ifdef FIFO_STATUS_EN
      chk("wnum", 36'(bus.Wnum), 36'(mq.size()));
      chk("aempty", 36'(bus.Almost_Empty), 36'(mq.size() <= 1));
`endif
      if (!bus.Empty && bus.RdEn) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL pop: got %h, expected no word", bus.Q);
        end else begin
          chk("q", bus.Q, sb.pop_front());
        end
      end
    end
  end

  task automatic step(input logic w, input logic r,
                      input logic [35:0] d);
    @(posedge clk);
    #1;
    bus.WrEn = w;
    bus.RdEn = r;
    bus.Data = d;
  endtask

  task automatic pulse_rst(input int n);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    bus.WrEn = 1'b0;
    bus.RdEn = 1'b0;
    repeat (n - 1) @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drain(input int n);
    repeat (n) step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 36'(base + i));
    step(1'b0, 1'b0, '0);
  endtask

  function automatic logic [35:0] rnd36();
    return {4'($urandom), 32'($urandom)};
  endfunction

  task automatic rand_run(input int n, input int pw, input int pr);
    for (int i = 0; i < n; i++)
      step($urandom_range(99) < pw, $urandom_range(99) < pr, rnd36());
  endtask

  initial begin
    bus.WrEn = 1'b0;
    bus.RdEn = 1'b0;
    bus.Data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b1;
    chk_en = 1'b1;

    repeat (2) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);

    step(1'b1, 1'b0, 36'h9_ABCD_1234);
    repeat (2) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, '0);
    repeat (2) step(1'b0, 1'b0, '0);

    for (int i = 0; i < 512; i++) step(1'b1, 1'b0, 36'(i));
    step(1'b1, 1'b0, 36'd999);
    step(1'b0, 1'b0, '0);
    drain(515);

    for (int i = 0; i < 1000; i++) step(1'b1, 1'b1, 36'(1000 + i));
    drain(4);

    fill(512, 5000);
    step(1'b1, 1'b1, 36'd999);
    step(1'b0, 1'b0, '0);
    drain(512);

    fill(100, 7000);
    pulse_rst(1);
    step(1'b1, 1'b0, 36'h0_0000_0ABC);
    repeat (2) step(1'b0, 1'b0, '0);
    drain(2);

    rand_run(1500, 85, 30);
    rand_run(1500, 30, 85);
    rand_run(1000, 50, 50);
    drain(520);

    @(negedge clk);
    chk("drained", 36'(sb.size()), 36'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
